// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the clearable dual-port RAM.
package dual_port_ram_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/dual_port_ram_clr_ctrl.sv
// Init/clear sequencer: sweeps every address once, then reports ready.
module dual_port_ram_clr_ctrl
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  ready,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam int unsigned          MEM_SIZE  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    // Next-state: single pass over the array, re-armed only by a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                if (clear) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State, counter and decoded flags registered from next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready   <= 1'b0;
            clr_en  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= (state_d == READY);
            clr_en  <= (state_d == INIT);
        end
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/dual_port_ram_clr.sv
// Dual-port RAM with byte enables, registered read and a zeroing sweep on reset/clear.
module dual_port_ram_clr
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          RDW_BYPASS = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             write_en_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en_i,
    input  logic [ADDR_WIDTH-1:0]            write_addr_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             read_en_i,
    input  logic [ADDR_WIDTH-1:0]            read_addr_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             rd_valid_o,
    output logic                             ready_o
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned MEM_SIZE  = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  ready;
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merge_word;
    logic [DATA_WIDTH-1:0] rd_word;

    dual_port_ram_clr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_i),
        .ready    (ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // A clear request wins over any access presented in the same cycle.
    assign wr_ok = ready && !clear_i && write_en_i;
    assign rd_ok = ready && !clear_i && read_en_i;

    // Byte-merged write word and read source, with optional new-data forwarding.
    always_comb begin
        old_word = mem[write_addr_i];
        merge_word = old_word;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (byte_en_i[b]) begin
                merge_word[b*BYTE_WIDTH +: BYTE_WIDTH] = data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = mem[read_addr_i];
        if (RDW_BYPASS && wr_ok && (write_addr_i == read_addr_i)) begin
            rd_word = merge_word;
        end
    end

    // Array update: init sweep zeroes one word per cycle, otherwise byte-enabled writes.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                if (byte_en_i[b]) begin
                    mem[write_addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Registered read port; data holds between reads, valid pulses per read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o     <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_ok;
            if (rd_ok) begin
                data_o <= rd_word;
            end
        end
    end

    assign ready_o = ready;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Directed bench: one instance per read-during-write mode, shared stimulus.
module tb_dual_port_ram_clr;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  be    = '0;
    logic [2:0]  wa    = '0;
    logic [2:0]  ra    = '0;
    logic [31:0] din   = '0;

    logic [31:0] data_new;
    logic [31:0] data_old;
    logic        valid_new;
    logic        valid_old;
    logic        ready_new;
    logic        ready_old;

    int n_checks = 0;
    int n_pass   = 0;
    int edges;
    logic saw_valid;

    always #5 clk = ~clk;

    dual_port_ram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .RDW_BYPASS(1'b1)) u_dut_new (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .write_en_i(we), .byte_en_i(be),
        .write_addr_i(wa), .data_i(din), .read_en_i(re), .read_addr_i(ra),
        .data_o(data_new), .rd_valid_o(valid_new), .ready_o(ready_new)
    );

    dual_port_ram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .RDW_BYPASS(1'b0)) u_dut_old (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .write_en_i(we), .byte_en_i(be),
        .write_addr_i(wa), .data_i(din), .read_en_i(re), .read_addr_i(ra),
        .data_o(data_old), .rd_valid_o(valid_old), .ready_o(ready_old)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; clear = 1'b0; be = '0;
    endtask

    task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; wa = a; din = d; be = b;
        step();
        we = 1'b0; be = '0;
    endtask

    task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        re = 1'b1; ra = a;
        step();
        re = 1'b0;
        check({tag, "_new"}, data_new, exp);
        check({tag, "_old"}, data_old, exp);
        check({tag, "_vld"}, 32'(valid_new), 32'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_new && n < 40);
    endtask

    initial begin
        #2;
        check("rst_data", data_new, 32'h0);
        check("rst_valid", 32'(valid_new), 32'd0);
        check("rst_ready", 32'(ready_new), 32'd0);
        step();
        step();
        check("rst_hold_ready", 32'(ready_new), 32'd0);
        rst_n = 1'b1;
        wait_ready(edges);
        check("init_edges", 32'(edges), 32'd8);
        check("init_ready_old", 32'(ready_old), 32'd1);
        for (int a = 0; a < 8; a++) read_expect("init_rd", 3'(a), 32'h0);

        step();
        check("idle_valid", 32'(valid_new), 32'd0);

        write(3'd2, 32'hDEADBEEF, 4'b1111);
        write(3'd2, 32'h11223344, 4'b0101);
        read_expect("be_merge", 3'd2, 32'hDE22BE44);
        step();
        check("hold_valid", 32'(valid_new), 32'd0);
        check("hold_data", data_new, 32'hDE22BE44);

        write(3'd2, 32'hFFFFFFFF, 4'b0000);
        read_expect("be_zero", 3'd2, 32'hDE22BE44);

        write(3'd5, 32'hAAAAAAAA, 4'b1111);
        we = 1'b1; wa = 3'd5; din = 32'h55555555; be = 4'b0011; re = 1'b1; ra = 3'd5;
        step();
        idle();
        check("rdw_new", data_new, 32'hAAAA5555);
        check("rdw_old", data_old, 32'hAAAAAAAA);
        check("rdw_vld_old", 32'(valid_old), 32'd1);
        read_expect("rdw_after", 3'd5, 32'hAAAA5555);

        we = 1'b1; wa = 3'd3; din = 32'h12345678; be = 4'b1111; re = 1'b1; ra = 3'd2;
        step();
        idle();
        check("diff_rd_new", data_new, 32'hDE22BE44);
        check("diff_rd_old", data_old, 32'hDE22BE44);
        read_expect("diff_wr", 3'd3, 32'h12345678);

        for (int a = 0; a < 8; a++) write(3'(a), 32'h01010101 * 32'(a + 1), 4'b1111);
        read_expect("fill", 3'd7, 32'h08080808);

        clear = 1'b1; we = 1'b1; wa = 3'd1; din = 32'hCAFEF00D; be = 4'b1111; re = 1'b1; ra = 3'd7;
        step();
        clear = 1'b0;
        check("clr_ready_new", 32'(ready_new), 32'd0);
        check("clr_ready_old", 32'(ready_old), 32'd0);
        check("clr_valid", 32'(valid_new), 32'd0);
        we = 1'b1; wa = 3'd0; din = 32'hFFFFFFFF; be = 4'b1111; re = 1'b1; ra = 3'd0;
        saw_valid = 1'b0;
        edges = 0;
        do begin
            step();
            edges++;
            if (valid_new || valid_old) saw_valid = 1'b1;
        end while (!ready_new && edges < 40);
        idle();
        check("clr_edges", 32'(edges), 32'd8);
        check("clr_no_valid", 32'(saw_valid), 32'd0);
        check("clr_hold_data", data_new, 32'h08080808);
        for (int a = 0; a < 8; a++) read_expect("clr_rd", 3'(a), 32'h0);

        write(3'd6, 32'h0BADCAFE, 4'b1111);
        read_expect("pre_rst", 3'd6, 32'h0BADCAFE);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_data_new", data_new, 32'h0);
        check("arst_data_old", data_old, 32'h0);
        check("arst_valid", 32'(valid_new), 32'd0);
        check("arst_ready", 32'(ready_new), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_ready(edges);
        check("arst_edges", 32'(edges), 32'd8);
        read_expect("post_rst6", 3'd6, 32'h0);
        read_expect("post_rst3", 3'd3, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
